// File: rtl/flits_buffer.sv
// flits_buffer: holds one packet of up to MAX_PACKET_LENGHT flits and returns one credit per stored flit after release.
// Optional feature: define FLITS_BUFFER_CLEAR_ON_RELEASE_EN to zero every slot on the grant edge.
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 64
`endif
`ifndef MAX_PACKET_LENGHT
`define MAX_PACKET_LENGHT 8
`endif

module flits_buffer #(
   parameter int N_BITS_POINTER = $clog2(`MAX_PACKET_LENGHT)
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic [`FLIT_WIDTH-1:0]                     in_link_i,
   input  logic                                       is_valid_i,
   output logic                                       credit_signal_o,
   output logic                                       free_signal_o,
   input  logic                                       g_pkt_to_msg_i,
   output logic                                       r_pkt_to_msg_o,
   output logic [`MAX_PACKET_LENGHT*`FLIT_WIDTH-1:0]  out_link_o,
   output logic [`MAX_PACKET_LENGHT-1:0]              out_sel_o
);

   localparam int FW = `FLIT_WIDTH;
   localparam int NS = `MAX_PACKET_LENGHT;
   // One extra bit so the pointer can express "all slots used".
   localparam int PW = N_BITS_POINTER + 1;
   localparam logic [PW-1:0] PTR_FULL = PW'(NS);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);

   localparam logic [1:0] FT_HEAD      = 2'b00;
   localparam logic [1:0] FT_TAIL      = 2'b10;
   localparam logic [1:0] FT_HEAD_TAIL = 2'b11;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      RECEIVING = 2'b01,
      READY     = 2'b10,
      CREDIT    = 2'b11
   } state_t;

   state_t                          state_r;
   state_t                          state_nxt_s;
   logic [PW-1:0]                   ptr_r;
   logic [PW-1:0]                   ptr_nxt_s;
   logic [PW-1:0]                   cnt_r;
   logic [PW-1:0]                   cnt_nxt_s;
   logic [NS-1:0]                   sel_r;
   logic [NS-1:0]                   sel_nxt_s;
   logic                            credit_r;
   logic                            credit_nxt_s;
   logic                            req_r;
   logic                            free_r;
   logic                            wr_en_s;
   logic [N_BITS_POINTER-1:0]       wr_idx_s;
   logic                            clear_s;
   logic [1:0]                      flit_type_s;
   logic [NS-1:0][FW-1:0]           slot_r;

   assign flit_type_s     = in_link_i[1:0];
   assign out_link_o      = slot_r;
   assign out_sel_o       = sel_r;
   assign credit_signal_o = credit_r;
   assign r_pkt_to_msg_o  = req_r;
   assign free_signal_o   = free_r;

   // Next-state, slot write control and credit generation.
   always_comb begin
      state_nxt_s  = state_r;
      ptr_nxt_s    = ptr_r;
      cnt_nxt_s    = cnt_r;
      sel_nxt_s    = sel_r;
      credit_nxt_s = 1'b0;
      wr_en_s      = 1'b0;
      wr_idx_s     = ptr_r[N_BITS_POINTER-1:0];
      clear_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (is_valid_i && ((flit_type_s == FT_HEAD) || (flit_type_s == FT_HEAD_TAIL))) begin
               wr_en_s     = 1'b1;
               wr_idx_s    = {N_BITS_POINTER{1'b0}};
               sel_nxt_s   = NS'(1'b1);
               ptr_nxt_s   = PTR_ONE;
               state_nxt_s = (flit_type_s == FT_HEAD) ? RECEIVING : READY;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RECEIVING: begin
            if (is_valid_i) begin
               // Flits beyond the last slot are dropped, but a tail still closes the packet.
               if (ptr_r < PTR_FULL) begin
                  wr_en_s             = 1'b1;
                  sel_nxt_s[wr_idx_s] = 1'b1;
                  ptr_nxt_s           = ptr_r + PTR_ONE;
               end else begin
                  wr_en_s = 1'b0;
               end
               if (flit_type_s == FT_TAIL) begin
                  state_nxt_s = READY;
               end else begin
                  state_nxt_s = RECEIVING;
               end
            end else begin
               state_nxt_s = RECEIVING;
            end
         end
         READY: begin
            if (g_pkt_to_msg_i) begin
               cnt_nxt_s    = ptr_r;
               ptr_nxt_s    = {PW{1'b0}};
               sel_nxt_s    = {NS{1'b0}};
               credit_nxt_s = 1'b1;
               state_nxt_s  = CREDIT;
`ifdef FLITS_BUFFER_CLEAR_ON_RELEASE_EN
               clear_s      = 1'b1;
`else
               clear_s      = 1'b0;
`endif
            end else begin
               state_nxt_s = READY;
            end
         end
         CREDIT: begin
            // cnt_r counts the pulses still owed, including the one showing now.
            if (cnt_r > PTR_ONE) begin
               cnt_nxt_s    = cnt_r - PTR_ONE;
               credit_nxt_s = 1'b1;
               state_nxt_s  = CREDIT;
            end else begin
               cnt_nxt_s    = {PW{1'b0}};
               credit_nxt_s = 1'b0;
               state_nxt_s  = IDLE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            ptr_nxt_s   = {PW{1'b0}};
            cnt_nxt_s   = {PW{1'b0}};
            sel_nxt_s   = {NS{1'b0}};
         end
      endcase
   end

   // Control state and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         ptr_r    <= {PW{1'b0}};
         cnt_r    <= {PW{1'b0}};
         sel_r    <= {NS{1'b0}};
         credit_r <= 1'b0;
         req_r    <= 1'b0;
         free_r   <= 1'b1;
      end else begin
         state_r  <= state_nxt_s;
         ptr_r    <= ptr_nxt_s;
         cnt_r    <= cnt_nxt_s;
         sel_r    <= sel_nxt_s;
         credit_r <= credit_nxt_s;
         req_r    <= (state_nxt_s == READY);
         free_r   <= (state_nxt_s == IDLE);
      end
   end

   // Slot storage.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_r <= '0;
      end else if (clear_s) begin
         slot_r <= '0;
      end else if (wr_en_s) begin
         slot_r[wr_idx_s] <= in_link_i;
      end else begin
         slot_r <= slot_r;
      end
   end

endmodule

// File: tb/tb_flits_buffer.sv
// Scoreboard bench for flits_buffer: directed scenarios plus randomized packets against a packet-level model.
`timescale 1ns/1ps
module tb_flits_buffer;

   logic          clk = 1'b0;
   logic          rst;
   logic [63:0]   in_link_i;
   logic          is_valid_i;
   logic          credit_signal_o;
   logic          free_signal_o;
   logic          g_pkt_to_msg_i;
   logic          r_pkt_to_msg_o;
   logic [511:0]  out_link_o;
   logic [7:0]    out_sel_o;

   typedef struct {
      logic [7:0]       sel;
      logic [7:0][63:0] data;
      int               n;
   } pkt_t;

   int          n_vec = 0;
   int          n_err = 0;
   pkt_t        exp_pkt_q[$];
   int          exp_cred_q[$];
   logic [63:0] cur_q[$];
   int          m_last_n = 0;

   flits_buffer dut (
      .clk             (clk),
      .rst             (rst),
      .in_link_i       (in_link_i),
      .is_valid_i      (is_valid_i),
      .credit_signal_o (credit_signal_o),
      .free_signal_o   (free_signal_o),
      .g_pkt_to_msg_i  (g_pkt_to_msg_i),
      .r_pkt_to_msg_o  (r_pkt_to_msg_o),
      .out_link_o      (out_link_o),
      .out_sel_o       (out_sel_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [63:0] d, input logic g);
      is_valid_i     = v;
      in_link_i      = d;
      g_pkt_to_msg_i = g;
      tick();
      is_valid_i     = 1'b0;
      g_pkt_to_msg_i = 1'b0;
   endtask

   function automatic logic [63:0] mk(input logic [1:0] t, input logic [63:0] pl);
      return {pl[63:2], t};
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   // Model: a packet keeps its first eight flits; credits equal the number kept.
   task automatic end_pkt();
      pkt_t p;
      p.n    = (cur_q.size() > 8) ? 8 : cur_q.size();
      p.sel  = '0;
      p.data = '0;
      for (int i = 0; i < p.n; i++) begin
         p.sel[i]  = 1'b1;
         p.data[i] = cur_q[i];
      end
      exp_pkt_q.push_back(p);
      m_last_n = p.n;
      cur_q.delete();
   endtask

   task automatic send_flit(input logic [63:0] d);
      drive(1'b1, d, 1'b0);
      cur_q.push_back(d);
   endtask

   task automatic wait_req();
      int k = 0;
      while (r_pkt_to_msg_o !== 1'b1 && k < 10) begin
         tick();
         k++;
      end
      chk("req_wait", r_pkt_to_msg_o, 64'd1);
   endtask

   task automatic grant_pkt();
      wait_req();
      exp_cred_q.push_back(m_last_n);
      drive(1'b0, 64'd0, 1'b1);
      chk("grant_sel_clear", out_sel_o, 64'd0);
      chk("grant_req_drop", r_pkt_to_msg_o, 64'd0);
      chk("grant_first_credit", credit_signal_o, 64'd1);
   endtask

   task automatic wait_free();
      int k = 0;
      while (free_signal_o !== 1'b1 && k < 20) begin
         tick();
         k++;
      end
      chk("free_wait", free_signal_o, 64'd1);
   endtask

   // Monitor: pops an expected packet on each request rise and an expected count at the end of each credit burst.
   initial begin
      logic prev_req;
      int   burst;
      pkt_t p;
      prev_req = 1'b0;
      burst    = 0;
      forever begin
         @(negedge clk);
         if (rst !== 1'b0) begin
            prev_req = 1'b0;
            burst    = 0;
         end else begin
            if (r_pkt_to_msg_o === 1'b1 && !prev_req) begin
               if (exp_pkt_q.size() == 0) begin
                  chk("unexpected_req", r_pkt_to_msg_o, 64'd0);
               end else begin
                  p = exp_pkt_q.pop_front();
                  chk("pkt_sel", out_sel_o, p.sel);
                  for (int i = 0; i < p.n; i++)
                     chk($sformatf("pkt_slot%0d", i), out_link_o[i*64 +: 64], p.data[i]);
               end
            end
            prev_req = (r_pkt_to_msg_o === 1'b1);
            if (credit_signal_o === 1'b1) begin
               burst++;
            end else if (burst != 0) begin
               if (exp_cred_q.size() == 0) chk("unexpected_credit", burst, 64'd0);
               else                        chk("credit_burst", burst, exp_cred_q.pop_front());
               burst = 0;
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] d;
      logic [63:0] h;
      logic [63:0] b1;
      logic [63:0] t;
      int          nb;
      rst            = 1'b1;
      in_link_i      = 64'd0;
      is_valid_i     = 1'b0;
      g_pkt_to_msg_i = 1'b0;
      repeat (3) tick();
      chk("rst_free", free_signal_o, 64'd1);
      chk("rst_slots_zero", {63'd0, |out_link_o}, 64'd0);
      rst = 1'b0;
      tick();
      chk("reset_free", free_signal_o, 64'd1);
      chk("reset_req", r_pkt_to_msg_o, 64'd0);
      chk("reset_sel", out_sel_o, 64'd0);
      chk("reset_credit", credit_signal_o, 64'd0);
      repeat (3) tick();

      // Single head-tail flit.
      send_flit(64'hFF3);
      end_pkt();
      chk("ht_req", r_pkt_to_msg_o, 64'd1);
      chk("ht_sel", out_sel_o, 64'h01);
      chk("ht_slot0", out_link_o[63:0], 64'hFF3);
      grant_pkt();
      wait_free();
      chk("ht_credit_done", credit_signal_o, 64'd0);

      // Five-flit packet with one stall cycle.
      send_flit(64'h00);
      chk("rx_not_free", free_signal_o, 64'd0);
      send_flit(64'h11);
      send_flit(64'h21);
      drive(1'b0, 64'd0, 1'b0);
      send_flit(64'h31);
      chk("rx_req_low", r_pkt_to_msg_o, 64'd0);
      send_flit(64'h72);
      end_pkt();
      chk("five_sel", out_sel_o, 64'h1F);
      chk("five_req", r_pkt_to_msg_o, 64'd1);
      grant_pkt();
      wait_free();

      // Early grants are ignored, and so are flits while the packet waits.
      h  = mk(2'b00, 64'hA0);
      b1 = mk(2'b01, 64'hB4);
      t  = mk(2'b10, 64'hC8);
      send_flit(h);
      drive(1'b0, 64'd0, 1'b1);
      is_valid_i = 1'b1; in_link_i = b1; g_pkt_to_msg_i = 1'b1;
      tick();
      is_valid_i = 1'b0; g_pkt_to_msg_i = 1'b0;
      cur_q.push_back(b1);
      chk("early_grant_req", r_pkt_to_msg_o, 64'd0);
      chk("early_grant_sel", out_sel_o, 64'h03);
      send_flit(t);
      end_pkt();
      drive(1'b1, mk(2'b00, 64'hDEAD00), 1'b0);
      drive(1'b1, mk(2'b11, 64'hBEEF00), 1'b0);
      drive(1'b1, mk(2'b01, 64'h5500), 1'b0);
      chk("ready_sel_hold", out_sel_o, 64'h07);
      chk("ready_slot0", out_link_o[63:0], h);
      chk("ready_slot1", out_link_o[127:64], b1);
      chk("ready_slot2", out_link_o[191:128], t);
      grant_pkt();
`ifdef FLITS_BUFFER_CLEAR_ON_RELEASE_EN
      chk("release_slot0", out_link_o[63:0], 64'd0);
`else
      chk("release_slot0", out_link_o[63:0], h);
`endif
      wait_free();

      // Overflow: head, nine bodies, tail.
      send_flit(mk(2'b00, 64'h1000));
      for (int i = 0; i < 9; i++) send_flit(mk(2'b01, 64'h2000 + 64'(i) * 64'h10));
      send_flit(mk(2'b10, 64'h3000));
      end_pkt();
      chk("ovf_sel", out_sel_o, 64'hFF);
      grant_pkt();
      wait_free();

      // Reset in the middle of a packet, then a stray body in IDLE.
      send_flit(mk(2'b00, 64'h4400));
      send_flit(mk(2'b01, 64'h4410));
      send_flit(mk(2'b01, 64'h4420));
      chk("mid_sel", out_sel_o, 64'h07);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cur_q.delete();
      chk("abort_free", free_signal_o, 64'd1);
      chk("abort_sel", out_sel_o, 64'd0);
      chk("abort_req", r_pkt_to_msg_o, 64'd0);
      chk("abort_credit", credit_signal_o, 64'd0);
      chk("abort_slots_zero", {63'd0, |out_link_o}, 64'd0);
      drive(1'b1, mk(2'b01, 64'h7700), 1'b0);
      chk("idle_body_sel", out_sel_o, 64'd0);
      chk("idle_body_free", free_signal_o, 64'd1);
      repeat (3) tick();

      // Randomized packets.
      for (int p = 0; p < 25; p++) begin
         if ($urandom_range(0, 1) == 1)
            drive(1'b1, mk(2'($urandom_range(1, 2)), rnd64()), 1'($urandom_range(0, 1)));
         chk("rnd_idle_sel", out_sel_o, 64'd0);
         if ($urandom_range(0, 4) == 0) begin
            send_flit(mk(2'b11, rnd64()));
            end_pkt();
         end else begin
            send_flit(mk(2'b00, rnd64()));
            nb = $urandom_range(0, 10);
            for (int b = 0; b < nb; b++) begin
               if ($urandom_range(0, 3) == 0) drive(1'b0, rnd64(), 1'($urandom_range(0, 1)));
               d = mk(($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 1) * 3) : 2'b01, rnd64());
               is_valid_i = 1'b1; in_link_i = d; g_pkt_to_msg_i = 1'($urandom_range(0, 1));
               tick();
               is_valid_i = 1'b0; g_pkt_to_msg_i = 1'b0;
               cur_q.push_back(d);
            end
            send_flit(mk(2'b10, rnd64()));
            end_pkt();
         end
         repeat ($urandom_range(0, 3)) drive(1'b1, rnd64(), 1'b0);
         grant_pkt();
         repeat ($urandom_range(0, 3)) drive(1'b1, mk(2'b01, rnd64()), 1'b0);
         wait_free();
      end

      repeat (3) tick();
      chk("pkt_queue_drained", exp_pkt_q.size(), 64'd0);
      chk("credit_queue_drained", exp_cred_q.size(), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
